parallel_serial: RTL and testbench
==================================

# parallel_serial

Transmit-side serializer for the serial link: accepts 8-bit words from the parallel datapath and shifts them out MSB-first, one bit per `clk_32f` cycle, on a single serial line. After reset it emits a sync preamble of COM (0xBC) symbols so the downstream `serial_parallel` receiver can lock. During idle periods it fills the line with COM symbols. It is the transmitter counterpart of `serial_parallel`, and the two are meant to run in loopback from a shared `clk_32f`.

## Interface
Parameters:
- `COM_SYMBOL`, default 8'hBC: the idle/sync symbol sent when no valid data is present.
- `N_SYNC`, default 4: the number of COM symbols forced after reset before data is accepted. Legal range is 1..15.

Ports:
- `clk_32f`  input  1  bit clock; all state changes on its rising edge.
- `reset`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `Data_in`  input  8  parallel word to transmit.
- `valid_in`  input  1  qualifies `Data_in`. Sampled only on a load edge.
- `ready_out`  output  1  high in the cycle whose rising edge will sample `Data_in`/`valid_in`.
- `Data_out`  output  1  serial bit stream, MSB first.

## Operation
State registers:
- `bit_cnt[2:0]`: bit position within the current symbol.
- `shreg[7:0]`: shift register.
- `sync_cnt[3:0]`: number of sync symbols loaded so far.
- FSM state: `SYNC` or `ACTIVE`.

Reset (`reset` = 0, asynchronous):
- `bit_cnt` = 7, `shreg` = 0, `sync_cnt` = 0, state = `SYNC`.
- Outputs: `Data_out` = 0, `ready_out` = 0. Both take these values immediately, with no clock needed.

Load edge: any rising edge where `bit_cnt` = 7. On a load edge, `bit_cnt` goes to 0 and `shreg` loads a new symbol:
- In `SYNC`: `shreg` ← `COM_SYMBOL` regardless of `valid_in`, and `sync_cnt` increments. When `sync_cnt` reaches `N_SYNC` (this load makes the count equal `N_SYNC`), state → `ACTIVE`.
- In `ACTIVE`: `shreg` ← `Data_in` if `valid_in` = 1, otherwise `COM_SYMBOL`.

Non-load edge: `shreg` ← `shreg` << 1 (zero fill) and `bit_cnt` increments.

Outputs:
- `Data_out` = `shreg[7]`.
- `ready_out` = 1 exactly when `reset` = 1, state = `ACTIVE`, and `bit_cnt` = 7. It is low during the whole `SYNC` phase.

Other rules:
- There is no back-pressure. Upstream must present the next word in the `ready_out` cycle, or that slot becomes a COM symbol.
- A word whose value equals 0xBC with `valid_in` = 1 is transmitted unchanged. Distinguishing it from idle is the receiver's concern.
- `sync_cnt` saturates once the state is `ACTIVE`. `SYNC` is re-entered only through reset.

## Timing
- Symbol period is 8 `clk_32f` cycles, with a load edge every 8th edge. `bit_cnt` wraps 7 → 0 only on a load edge.
- First edge after reset deassertion is a load edge (because `bit_cnt` resets to 7). The first COM bit appears on `Data_out` right after that edge.
- Latency: bit 7 of a word sampled at load edge E is on `Data_out` in the cycle after E. Bit 0 is on `Data_out` in the cycle before edge E+8.
- Sync phase lasts `N_SYNC` × 8 cycles. `ready_out` first rises in the 8th cycle of the last sync symbol, which is cycle 8·`N_SYNC` after the first edge. The first data word is loaded at edge 8·`N_SYNC` + 1.
- Back-to-back words: with `valid_in` held at 1 every `ready_out` cycle, the output is a continuous stream with no gap bits.
- Reset mid-symbol (asynchronous): the partial symbol is discarded, `Data_out` drops to 0 immediately, and the full sync preamble is re-sent after release.
- `Data_in` and `valid_in` in non-`ready_out` cycles are don't-care and must not affect the output.

## Test plan
- **Reset values:** hold `reset` = 0 for 5 cycles with `valid_in` = 1 and `Data_in` = 8'hFF → `Data_out` = 0 and `ready_out` = 0 throughout.
- **Sync preamble:** release reset with `valid_in` = 1 and `Data_in` = 8'h55 → first 32 serial bits are 1011_1100 ×4, and `ready_out` stays low until cycle 32.
- **Single word:** in the first `ready_out` cycle, drive `Data_in` = 8'hA5, `valid_in` = 1, then drop `valid_in` → serial 1010_0101 follows, then 1011_1100 repeated.
- **Back-to-back words:** 8'h01, 8'h80, 8'hFF on consecutive `ready_out` cycles → 0000_0001 1000_0000 1111_1111 with no gaps. Changing `Data_in` between `ready_out` cycles has no effect.
- **Reset mid-word:** assert `reset` at bit 3 of 8'hA5 → `Data_out` = 0 immediately. After release, 4 COM symbols are sent before `ready_out` rises again.
- **Loopback with `serial_parallel`:** drive words 8'h12, 8'h34, 8'h56 with idle gaps → receiver reports `valid_out` = 1 with `Data_out` 8'h12, 8'h34, 8'h56 in order, and `valid_out` = 0 during the COM gaps.

Source files
------------

// File: rtl/parallel_serial.sv
// parallel_serial: MSB-first 8-bit serializer for the serial link.
// Sends a COM preamble after reset, then data words or COM idle fill.
module parallel_serial #(
  parameter logic [7:0] COM_SYMBOL = 8'hBC,
  parameter int         N_SYNC     = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic [7:0] Data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       Data_out
);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  localparam logic [3:0] SYNC_LAST = 4'(N_SYNC - 1);

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [3:0] sync_cnt;
  logic       load;

  assign load = (bit_cnt == 3'd7);

  // Symbol framing: load a fresh symbol every 8th edge, shift otherwise.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      state    <= SYNC;
      bit_cnt  <= 3'd7;
      shreg    <= 8'h00;
      sync_cnt <= 4'd0;
    end else if (load) begin
      bit_cnt <= 3'd0;
      unique case (state)
        SYNC: begin
          shreg    <= COM_SYMBOL;
          sync_cnt <= sync_cnt + 4'd1;
          if (sync_cnt == SYNC_LAST)
            state <= ACTIVE;
        end
        ACTIVE: begin
          shreg <= valid_in ? Data_in : COM_SYMBOL;
        end
        default: begin
          state <= SYNC;
        end
      endcase
    end else begin
      shreg   <= {shreg[6:0], 1'b0};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  assign Data_out  = shreg[7];
  assign ready_out = reset & (state == ACTIVE) & load;

endmodule

// File: tb/tb_parallel_serial.sv
// tb_parallel_serial: vector table, hand sequences and random traffic
// checked against an edge-indexed model of the serial stream.
module tb_parallel_serial;

  localparam logic [7:0] COM = 8'hBC;
  localparam int         NS  = 4;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b0;
  logic [7:0] Data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       Data_out;

  parallel_serial #(
    .COM_SYMBOL(COM),
    .N_SYNC    (NS)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .Data_in  (Data_in),
    .valid_in (valid_in),
    .ready_out(ready_out),
    .Data_out (Data_out)
  );

  always #5 clk_32f = ~clk_32f;

  typedef struct {
    logic [7:0] din;
    logic       vin;
    logic [7:0] exp_sym;
  } vec_t;

  int         passed = 0;
  int         total  = 0;
  int         k      = 0;
  logic [7:0] cur_sym = 8'h00;
  logic [7:0] got;
  vec_t       vecs[7];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One clock: model derives the symbol of each 8-edge slot from its
  // index since reset release and the inputs present at its first edge.
  task automatic step();
    logic       v;
    logic [7:0] d;
    int         ph;
    v = valid_in;
    d = Data_in;
    @(posedge clk_32f);
    #1;
    k++;
    ph = (k - 1) % 8;
    if (ph == 0)
      cur_sym = (((k - 1) / 8) < NS) ? COM : (v ? d : COM);
    check($sformatf("bit k=%0d", k), 32'(Data_out), 32'(cur_sym[7 - ph]));
    check($sformatf("rdy k=%0d", k), 32'(ready_out),
          32'((k % 8 == 0) && (k >= 8 * NS)));
  endtask

  task automatic hold_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_32f);
      #1;
      check($sformatf("rst out %0d", i), {30'd0, ready_out, Data_out}, 32'd0);
    end
    @(negedge clk_32f);
    reset = 1'b1;
    k = 0;
  endtask

  task automatic to_ready();
    while (k % 8 != 0 || k < 8 * NS) begin
      Data_in  = 8'($urandom);
      valid_in = 1'($urandom);
      step();
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 8'hA5};
    vecs[1] = '{8'h33, 1'b0, COM};
    vecs[2] = '{8'h01, 1'b1, 8'h01};
    vecs[3] = '{8'h80, 1'b1, 8'h80};
    vecs[4] = '{8'hFF, 1'b1, 8'hFF};
    vecs[5] = '{8'hBC, 1'b1, 8'hBC};
    vecs[6] = '{8'h00, 1'b1, 8'h00};

    // Reset values with busy inputs
    valid_in = 1'b1;
    Data_in  = 8'hFF;
    #1;
    check("rst async", {30'd0, ready_out, Data_out}, 32'd0);
    hold_reset(5);

    // Sync preamble with valid data pending
    Data_in = 8'h55;
    for (int i = 0; i < 8 * NS; i++) step();

    // Table: one word per ready slot, inputs scrambled between slots
    for (int r = 0; r < 7; r++) begin
      check($sformatf("vec%0d ready", r), 32'(ready_out), 32'd1);
      Data_in  = vecs[r].din;
      valid_in = vecs[r].vin;
      got = 8'h00;
      for (int b = 0; b < 8; b++) begin
        step();
        got = {got[6:0], Data_out};
        Data_in  = 8'($urandom);
        valid_in = 1'($urandom);
      end
      check($sformatf("vec%0d sym", r), 32'(got), 32'(vecs[r].exp_sym));
    end

    // Idle fill after a dropped valid
    valid_in = 1'b0;
    got = 8'h00;
    for (int b = 0; b < 8; b++) begin
      step();
      got = {got[6:0], Data_out};
    end
    check("idle sym", 32'(got), 32'(COM));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      Data_in  = 8'($urandom);
      valid_in = 1'($urandom);
      step();
    end

    // Reset in the middle of A5
    to_ready();
    Data_in  = 8'hA5;
    valid_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    #2;
    reset = 1'b0;
    #1;
    check("midword drop", {30'd0, ready_out, Data_out}, 32'd0);
    hold_reset(3);
    valid_in = 1'b1;
    Data_in  = 8'h5A;
    for (int i = 0; i < 8 * NS; i++) step();

    // Words with idle gaps after re-sync
    for (int w = 0; w < 3; w++) begin
      to_ready();
      Data_in  = 8'h12 + 8'(w * 8'h22);
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      for (int i = 0; i < 15; i++) step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
